// File: rtl/core_pkg.sv
// Shared decode-to-execute types for the segmented RV32I core.
package core_pkg;

    localparam int unsigned BUOP_W          = 5;
    localparam int unsigned BUOP_BRANCH_BIT = 3;
    localparam int unsigned BUOP_JUMP_BIT   = 4;

    typedef struct packed {
        logic              ALUASrc;
        logic              ALUBSrc;
        logic [3:0]        ALUOp;
        logic              DMWr;
        logic [2:0]        DMCtrl;
        logic [1:0]        RUDatawrSrc;
        logic              RuWr;
        logic [BUOP_W-1:0] BUOp;
        logic              DMrd;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard check between the ID instruction and a load sitting in EX.
module hazard_detect #(
    parameter int unsigned RA_W = 5
) (
    input  logic            id_valid_i,
    input  logic            id_alua_src_i,
    input  logic            id_alub_src_i,
    input  logic            id_dm_wr_i,
    input  logic            id_bu_branch_i,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic            ex_valid_i,
    input  logic            ex_dm_rd_i,
    input  logic [RA_W-1:0] ex_rd_i,
    output logic            hz_stall_c
);

    logic uses_rs1_c;
    logic uses_rs2_c;

    // Branches read both sources even though their ALU inputs are PC/imm.
    assign uses_rs1_c = id_valid_i & (~id_alua_src_i | id_bu_branch_i);
    assign uses_rs2_c = id_valid_i & (~id_alub_src_i | id_dm_wr_i | id_bu_branch_i);

    assign hz_stall_c = ex_valid_i & ex_dm_rd_i & (ex_rd_i != '0)
                      & ((uses_rs1_c & (id_rs1_i == ex_rd_i))
                       | (uses_rs2_c & (id_rs2_i == ex_rd_i)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble, EX flush and stall counter.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              id_ALUASrc,
    input  logic              id_ALUBSrc,
    input  logic [3:0]        id_ALUOp,
    input  logic              id_DMWr,
    input  logic              id_DMrd,
    input  logic              id_RuWr,
    input  logic [2:0]        id_DMCtrl,
    input  logic [1:0]        id_RUDatawrSrc,
    input  logic [BUOP_W-1:0] id_BUOp,
    input  logic              ex_flush,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [RA_W-1:0]   ex_rs1,
    output logic [RA_W-1:0]   ex_rs2,
    output logic [RA_W-1:0]   ex_rd,
    output logic              ex_ALUASrc,
    output logic              ex_ALUBSrc,
    output logic [3:0]        ex_ALUOp,
    output logic              ex_DMWr,
    output logic              ex_DMrd,
    output logic              ex_RuWr,
    output logic [2:0]        ex_DMCtrl,
    output logic [1:0]        ex_RUDatawrSrc,
    output logic [BUOP_W-1:0] ex_BUOp,
    output logic              hz_stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    ctrl_t             id_ctrl_c;
    ctrl_t             ctrl_d,  ctrl_q;
    logic              valid_d, valid_q;
    logic [XLEN-1:0]   pc_d,    pc_q;
    logic [XLEN-1:0]   rs1d_d,  rs1d_q;
    logic [XLEN-1:0]   rs2d_d,  rs2d_q;
    logic [XLEN-1:0]   imm_d,   imm_q;
    logic [RA_W-1:0]   rs1_d,   rs1_q;
    logic [RA_W-1:0]   rs2_d,   rs2_q;
    logic [RA_W-1:0]   rd_d,    rd_q;
    logic [CNT_W-1:0]  cnt_d,   cnt_q;

    assign id_ctrl_c = '{ALUASrc: id_ALUASrc, ALUBSrc: id_ALUBSrc, ALUOp: id_ALUOp,
                         DMWr: id_DMWr, DMCtrl: id_DMCtrl, RUDatawrSrc: id_RUDatawrSrc,
                         RuWr: id_RuWr, BUOp: id_BUOp, DMrd: id_DMrd};

    hazard_detect #(.RA_W(RA_W)) u_hazard (
        .id_valid_i     (id_valid),
        .id_alua_src_i  (id_ALUASrc),
        .id_alub_src_i  (id_ALUBSrc),
        .id_dm_wr_i     (id_DMWr),
        .id_bu_branch_i (id_BUOp[BUOP_BRANCH_BIT]),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .ex_valid_i     (valid_q),
        .ex_dm_rd_i     (ctrl_q.DMrd),
        .ex_rd_i        (rd_q),
        .hz_stall_c     (hz_stall)
    );

    // Default is the all-zero bubble; only a clean cycle admits the ID instruction.
    always_comb begin
        ctrl_d  = CTRL_BUBBLE;
        valid_d = 1'b0;
        pc_d    = '0;
        rs1d_d  = '0;
        rs2d_d  = '0;
        imm_d   = '0;
        rs1_d   = '0;
        rs2_d   = '0;
        rd_d    = '0;
        cnt_d   = cnt_q;
        if (!ex_flush && !hz_stall) begin
            ctrl_d  = id_valid ? id_ctrl_c : CTRL_BUBBLE;
            valid_d = id_valid;
            pc_d    = id_pc;
            rs1d_d  = id_rs1_data;
            rs2d_d  = id_rs2_data;
            imm_d   = id_imm;
            rs1_d   = id_rs1;
            rs2_d   = id_rs2;
            rd_d    = id_rd;
        end
        if (hz_stall && !ex_flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= CTRL_BUBBLE;
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs1d_q  <= '0;
            rs2d_q  <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs1d_q  <= rs1d_d;
            rs2d_q  <= rs2d_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_pc          = pc_q;
    assign ex_rs1_data    = rs1d_q;
    assign ex_rs2_data    = rs2d_q;
    assign ex_imm         = imm_q;
    assign ex_rs1         = rs1_q;
    assign ex_rs2         = rs2_q;
    assign ex_rd          = rd_q;
    assign ex_ALUASrc     = ctrl_q.ALUASrc;
    assign ex_ALUBSrc     = ctrl_q.ALUBSrc;
    assign ex_ALUOp       = ctrl_q.ALUOp;
    assign ex_DMWr        = ctrl_q.DMWr;
    assign ex_DMrd        = ctrl_q.DMrd;
    assign ex_RuWr        = ctrl_q.RuWr;
    assign ex_DMCtrl      = ctrl_q.DMCtrl;
    assign ex_RUDatawrSrc = ctrl_q.RUDatawrSrc;
    assign ex_BUOp        = ctrl_q.BUOp;
    assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage (counter narrowed so saturation is reachable).
module tb_id_ex_stage;
    import core_pkg::*;

    localparam int unsigned CW = 8;

    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, ex_flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    ctrl_t       id_ctrl;

    logic        ex_valid, ex_ALUASrc, ex_ALUBSrc, ex_DMWr, ex_DMrd, ex_RuWr, hz_stall;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_BUOp;
    logic [3:0]  ex_ALUOp;
    logic [2:0]  ex_DMCtrl;
    logic [1:0]  ex_RUDatawrSrc;
    logic [CW-1:0] stall_cnt;
    ctrl_t       ex_ctrl;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_m  = 0;

    always #5 clk = ~clk;

    assign ex_ctrl = {ex_ALUASrc, ex_ALUBSrc, ex_ALUOp, ex_DMWr, ex_DMCtrl,
                      ex_RUDatawrSrc, ex_RuWr, ex_BUOp, ex_DMrd};

    id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_ALUASrc(id_ctrl.ALUASrc), .id_ALUBSrc(id_ctrl.ALUBSrc), .id_ALUOp(id_ctrl.ALUOp),
        .id_DMWr(id_ctrl.DMWr), .id_DMrd(id_ctrl.DMrd), .id_RuWr(id_ctrl.RuWr),
        .id_DMCtrl(id_ctrl.DMCtrl), .id_RUDatawrSrc(id_ctrl.RUDatawrSrc), .id_BUOp(id_ctrl.BUOp),
        .ex_flush(ex_flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_ALUASrc(ex_ALUASrc), .ex_ALUBSrc(ex_ALUBSrc), .ex_ALUOp(ex_ALUOp),
        .ex_DMWr(ex_DMWr), .ex_DMrd(ex_DMrd), .ex_RuWr(ex_RuWr),
        .ex_DMCtrl(ex_DMCtrl), .ex_RUDatawrSrc(ex_RUDatawrSrc), .ex_BUOp(ex_BUOp),
        .hz_stall(hz_stall), .stall_cnt(stall_cnt)
    );

    function automatic ctrl_t mk(input logic aa, input logic ab, input logic [3:0] op,
                                 input logic dmwr, input logic [2:0] dmc, input logic [1:0] wsrc,
                                 input logic ruwr, input logic [4:0] bu, input logic dmrd);
        ctrl_t c;
        c = '{ALUASrc: aa, ALUBSrc: ab, ALUOp: op, DMWr: dmwr, DMCtrl: dmc,
              RUDatawrSrc: wsrc, RuWr: ruwr, BUOp: bu, DMrd: dmrd};
        return c;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input ctrl_t c, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
        id_valid    = v;
        id_ctrl     = c;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_rs1_data = d1;
        id_rs2_data = d2;
        id_pc       = 32'h1000 + 32'(rd) * 4;
        id_imm      = 32'hFFFF_FF00 | 32'(rs2);
    endtask

    // Checks hz_stall now, queues the expected EX contents, compares them after the edge.
    task automatic step(input logic exp_stall, input logic exp_bubble, input int exp_cnt, input string tag);
        exp_t e;
        exp_t o;
        #1;
        chk({tag, ".stall"}, 128'(hz_stall), 128'(exp_stall));
        e = '0;
        if (!exp_bubble) begin
            e.valid = id_valid;
            e.ctrl  = id_valid ? id_ctrl : CTRL_BUBBLE;
            e.pc    = id_pc;
            e.rs1d  = id_rs1_data;
            e.rs2d  = id_rs2_data;
            e.imm   = id_imm;
            e.rs1   = id_rs1;
            e.rs2   = id_rs2;
            e.rd    = id_rd;
        end
        e.cnt = CW'(exp_cnt);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        o = sbq.pop_front();
        chk({tag, ".valid"}, 128'(ex_valid), 128'(o.valid));
        chk({tag, ".ctrl"},  128'(ex_ctrl),  128'(o.ctrl));
        chk({tag, ".data"},  {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm}, {o.pc, o.rs1d, o.rs2d, o.imm});
        chk({tag, ".regs"},  128'({ex_rs1, ex_rs2, ex_rd}), 128'({o.rs1, o.rs2, o.rd}));
        chk({tag, ".cnt"},   128'(stall_cnt), 128'(o.cnt));
        @(negedge clk);
    endtask

    ctrl_t RTYPE, LOAD, ADDI, JAL, BEQ, STORE;

    initial begin
        RTYPE = mk(1'b0, 1'b0, 4'b1000, 1'b0, 3'b000, 2'b00, 1'b1, 5'b00000, 1'b0);
        LOAD  = mk(1'b0, 1'b1, 4'b0000, 1'b0, 3'b010, 2'b01, 1'b1, 5'b00000, 1'b1);
        ADDI  = mk(1'b0, 1'b1, 4'b0000, 1'b0, 3'b000, 2'b00, 1'b1, 5'b00000, 1'b0);
        JAL   = mk(1'b1, 1'b1, 4'b0000, 1'b0, 3'b000, 2'b10, 1'b1, 5'b10000, 1'b0);
        BEQ   = mk(1'b1, 1'b1, 4'b0000, 1'b0, 3'b000, 2'b00, 1'b0, 5'b01000, 1'b0);
        STORE = mk(1'b0, 1'b1, 4'b0000, 1'b1, 3'b010, 2'b00, 1'b0, 5'b00000, 1'b0);

        rst = 1'b1;
        ex_flush = 1'b0;
        set_id(1'b0, CTRL_BUBBLE, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
        id_pc = '0; id_imm = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ctrl",  128'({ex_valid, ex_ctrl}), 128'(0));
        chk("reset.data",  {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm}, 128'(0));
        chk("reset.stall", 128'(hz_stall), 128'(0));
        chk("reset.cnt",   128'(stall_cnt), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        step(1'b0, 1'b0, 0, "idle");

        set_id(1'b1, RTYPE, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22);
        step(1'b0, 1'b0, 0, "rtype_pass");

        // Load-use on rs2: one bubble, then the R-type goes through.
        set_id(1'b1, LOAD, 5'd1, 5'd3, 5'd7, 32'h100, 32'h0);
        step(1'b0, 1'b0, 0, "load7");
        set_id(1'b1, RTYPE, 5'd3, 5'd7, 5'd8, 32'h33, 32'h44);
        cnt_m = 1;
        step(1'b1, 1'b1, cnt_m, "lu_rs2");
        step(1'b0, 1'b0, cnt_m, "lu_release");

        // No false stalls.
        set_id(1'b1, LOAD, 5'd1, 5'd3, 5'd7, 32'h100, 32'h0);
        step(1'b0, 1'b0, cnt_m, "load7b");
        set_id(1'b1, ADDI, 5'd2, 5'd7, 5'd9, 32'h55, 32'h66);
        step(1'b0, 1'b0, cnt_m, "addi_rs2f");
        set_id(1'b1, LOAD, 5'd1, 5'd3, 5'd7, 32'h100, 32'h0);
        step(1'b0, 1'b0, cnt_m, "load7c");
        set_id(1'b1, JAL, 5'd7, 5'd7, 5'd1, 32'h0, 32'h0);
        step(1'b0, 1'b0, cnt_m, "jal_rs1f");
        set_id(1'b1, LOAD, 5'd1, 5'd3, 5'd0, 32'h100, 32'h0);
        step(1'b0, 1'b0, cnt_m, "load_x0");
        set_id(1'b1, RTYPE, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0);
        step(1'b0, 1'b0, cnt_m, "x0_nostall");

        // Branch reads rs1 despite ALUASrc=1.
        set_id(1'b1, LOAD, 5'd1, 5'd3, 5'd7, 32'h100, 32'h0);
        step(1'b0, 1'b0, cnt_m, "load7d");
        set_id(1'b1, BEQ, 5'd7, 5'd4, 5'd0, 32'h0, 32'h0);
        cnt_m = 2;
        step(1'b1, 1'b1, cnt_m, "lu_branch");

        // Store data (rs2) depends on the load.
        set_id(1'b1, LOAD, 5'd1, 5'd3, 5'd7, 32'h100, 32'h0);
        step(1'b0, 1'b0, cnt_m, "load7e");
        set_id(1'b1, STORE, 5'd2, 5'd7, 5'd0, 32'h0, 32'h0);
        cnt_m = 3;
        step(1'b1, 1'b1, cnt_m, "lu_store");

        // Flush together with a hazard: bubble, counter frozen.
        set_id(1'b1, LOAD, 5'd1, 5'd3, 5'd7, 32'h100, 32'h0);
        step(1'b0, 1'b0, cnt_m, "load7f");
        set_id(1'b1, RTYPE, 5'd3, 5'd7, 5'd8, 32'h33, 32'h44);
        ex_flush = 1'b1;
        step(1'b1, 1'b1, cnt_m, "flush_stall");
        set_id(1'b1, BEQ, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0);
        step(1'b0, 1'b1, cnt_m, "flush_only");
        ex_flush = 1'b0;

        // Saturation on the narrowed counter.
        for (int i = 0; i < 260; i++) begin
            set_id(1'b1, LOAD, 5'd1, 5'd3, 5'd7, 32'(i), 32'h0);
            step(1'b0, 1'b0, cnt_m, "sat_load");
            set_id(1'b1, RTYPE, 5'd3, 5'd7, 5'd8, 32'(i), 32'h44);
            cnt_m = (cnt_m == 255) ? 255 : cnt_m + 1;
            step(1'b1, 1'b1, cnt_m, "sat_stall");
        end
        chk("sat_final", 128'(stall_cnt), 128'(8'hFF));

        set_id(1'b1, RTYPE, 5'd3, 5'd7, 5'd8, 32'h77, 32'h88);
        step(1'b0, 1'b0, cnt_m, "pre_reset");

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        chk("async.ctrl", 128'({ex_valid, ex_ctrl}), 128'(0));
        chk("async.data", {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm}, 128'(0));
        chk("async.regs", 128'({ex_rs1, ex_rs2, ex_rd}), 128'(0));
        chk("async.cnt",  128'(stall_cnt), 128'(0));
        chk("sb_empty",   128'(sbq.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
